// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the nibble-compare datapath controller: widths, state encoding
// and the packed bundle of datapath control strobes.
package datapath_ctrl_pkg;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned CMP_W   = 4;
  localparam int unsigned SUM_W   = 8;
  localparam int unsigned MATCH_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  typedef struct packed {
    logic sl_sum;
    logic sl_index;
    logic wr_cypher;
    logic wr_compared;
    logic wr_sum;
    logic wr_index;
    logic wr_sum_out;
  } dp_ctrl_t;

endpackage

// File: rtl/datapath_ctrl.sv
// Control FSM for the nibble-compare datapath: start/ready/done handshake, abort,
// match counter and a watchdog that traps a datapath whose stop flag never rises.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CHECK = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               stop,
  input  logic               equal,
  output logic               ready,
  output logic               done,
  output logic               error,
  output logic [MATCH_W-1:0] match_count,
  output logic               sl_sum,
  output logic               sl_index,
  output logic               wr_cypher,
  output logic               wr_compared,
  output logic               wr_sum,
  output logic               wr_index,
  output logic               wr_sum_out
);

  state_e             r_state;
  state_e             w_next;
  dp_ctrl_t           w_ctrl;
  logic [CNT_W-1:0]   r_wdog;
  logic [CNT_W-1:0]   w_wdog_next;
  logic [MATCH_W-1:0] r_match;
  logic [MATCH_W-1:0] w_match_next;
  logic               r_ready;
  logic               r_done;
  logic               r_error;

  // State, watchdog and handshake registers; flags are registered from the next state
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_wdog  <= '0;
      r_match <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wdog  <= w_wdog_next;
      r_match <= w_match_next;
      r_ready <= (w_next == ST_IDLE);
      r_done  <= (w_next == ST_DONE);
      r_error <= (w_next == ST_ERROR);
    end
  end

  // Next state and datapath strobes; abort suppresses every write in the cycle it is seen
  always_comb begin
    w_next       = r_state;
    w_ctrl       = '0;
    w_wdog_next  = '0;
    w_match_next = r_match;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next       = ST_LOAD;
          w_match_next = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else begin
          w_ctrl.wr_cypher   = 1'b1;
          w_ctrl.wr_compared = 1'b1;
          w_ctrl.wr_sum      = 1'b1;
          w_ctrl.wr_index    = 1'b1;
          w_next             = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (stop) begin
          w_ctrl.wr_sum_out = 1'b1;
          w_next            = ST_DONE;
        end else begin
          w_ctrl.wr_index = 1'b1;
          w_ctrl.sl_index = 1'b1;
          if (equal) begin
            w_ctrl.wr_sum = 1'b1;
            w_ctrl.sl_sum = 1'b1;
            if (r_match < MATCH_W'(NIBBLES)) begin
              w_match_next = r_match + MATCH_W'(1);
            end
          end
          w_wdog_next = r_wdog + CNT_W'(1);
          if (w_wdog_next == CNT_W'(MAX_CHECK)) begin
            w_next = ST_ERROR;
          end
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign sl_sum      = w_ctrl.sl_sum;
  assign sl_index    = w_ctrl.sl_index;
  assign wr_cypher   = w_ctrl.wr_cypher;
  assign wr_compared = w_ctrl.wr_compared;
  assign wr_sum      = w_ctrl.wr_sum;
  assign wr_index    = w_ctrl.wr_index;
  assign wr_sum_out  = w_ctrl.wr_sum_out;

  assign ready       = r_ready;
  assign done        = r_done;
  assign error       = r_error;
  assign match_count = r_match;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl with a behavioural nibble-compare datapath attached.
module tb_datapath_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       stop;
  logic       equal;
  logic       ready, done, error;
  logic [2:0] match_count;
  logic       sl_sum, sl_index, wr_cypher, wr_compared, wr_sum, wr_index, wr_sum_out;

  logic [15:0] cypher_in = 16'h0;
  logic [3:0]  compared_in = 4'h0;
  logic        force_nostop = 1'b0;

  logic [15:0] dp_cypher;
  logic [3:0]  dp_cmp;
  logic [7:0]  dp_sum;
  logic [7:0]  sum_out;
  logic [2:0]  dp_index;
  logic [3:0]  dp_nib;
  logic [6:0]  ctrl_v;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [6:0] CTRL_LOAD = 7'b0011110;
  localparam logic [6:0] CTRL_STOP = 7'b0000001;

  datapath_ctrl #(.MAX_CHECK(8), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .stop(stop), .equal(equal), .ready(ready), .done(done), .error(error),
    .match_count(match_count), .sl_sum(sl_sum), .sl_index(sl_index),
    .wr_cypher(wr_cypher), .wr_compared(wr_compared), .wr_sum(wr_sum),
    .wr_index(wr_index), .wr_sum_out(wr_sum_out)
  );

  always #5 clock = ~clock;

  assign ctrl_v = {sl_sum, sl_index, wr_cypher, wr_compared, wr_sum, wr_index, wr_sum_out};

  always_comb begin
    case (dp_index[1:0])
      2'd0:    dp_nib = dp_cypher[3:0];
      2'd1:    dp_nib = dp_cypher[7:4];
      2'd2:    dp_nib = dp_cypher[11:8];
      default: dp_nib = dp_cypher[15:12];
    endcase
  end
  assign stop  = (dp_index > 3'd3) && !force_nostop;
  assign equal = (dp_nib == dp_cmp);

  // Datapath model: not reset, so sum_out keeps its value across controller resets
  always @(posedge clock) begin
    if (wr_cypher)   dp_cypher <= cypher_in;
    if (wr_compared) dp_cmp    <= compared_in;
    if (wr_index)    dp_index  <= sl_index ? dp_index + 3'd1 : 3'd0;
    if (wr_sum)      dp_sum    <= sl_sum ? dp_sum + {4'd0, dp_cmp} : 8'd0;
    if (wr_sum_out)  sum_out   <= dp_sum;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Start sampled at edge k; checks LOAD at k+1, stop cycle at k+6, done at k+7, ready at k+8
  task automatic run_full(input string tag, input logic [15:0] cy, input logic [3:0] cmp,
                          input logic [7:0] exp_sum, input logic [2:0] exp_cnt);
    cypher_in   = cy;
    compared_in = cmp;
    start       = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_load_ctrl"}, {1'b0, ctrl_v}, {1'b0, CTRL_LOAD});
    chk({tag, "_load_ready"}, {7'd0, ready}, 8'd0);
    repeat (5) tick();
    chk({tag, "_stop_ctrl"}, {1'b0, ctrl_v}, {1'b0, CTRL_STOP});
    chk({tag, "_pre_done"}, {7'd0, done}, 8'd0);
    tick();
    chk({tag, "_done"}, {7'd0, done}, 8'd1);
    chk({tag, "_sum"}, sum_out, exp_sum);
    chk({tag, "_count"}, {5'd0, match_count}, {5'd0, exp_cnt});
    tick();
    chk({tag, "_done_drop"}, {7'd0, done}, 8'd0);
    chk({tag, "_ready"}, {7'd0, ready}, 8'd1);
  endtask

  initial begin
    int ndone;

    // Reset state
    tick();
    tick();
    chk("rst_ready", {7'd0, ready}, 8'd1);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_error", {7'd0, error}, 8'd0);
    chk("rst_count", {5'd0, match_count}, 8'd0);
    chk("rst_ctrl", {1'b0, ctrl_v}, 8'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_ctrl", {1'b0, ctrl_v}, 8'd0);

    // Basic runs
    run_full("r3a33", 16'h3A33, 4'h3, 8'd9, 3'd3);
    run_full("rffff", 16'hFFFF, 4'hF, 8'h3C, 3'd4);
    run_full("r1234", 16'h1234, 4'h9, 8'd0, 3'd0);
    run_full("r3a33b", 16'h3A33, 4'h3, 8'd9, 3'd3);

    // Abort in the second CHECK cycle
    cypher_in = 16'h3333; compared_in = 4'h3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    #1;
    chk("abort_ctrl", {1'b0, ctrl_v}, 8'd0);
    tick();
    abort = 1'b0;
    chk("abort_ready", {7'd0, ready}, 8'd1);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", 8'(ndone), 8'd0);
    chk("abort_sum_kept", sum_out, 8'd9);

    // Reset in CHECK
    cypher_in = 16'h3333; compared_in = 4'h3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_ctrl", {1'b0, ctrl_v}, 8'd0);
    chk("midrst_ready", {7'd0, ready}, 8'd1);
    chk("midrst_count", {5'd0, match_count}, 8'd0);
    chk("midrst_sum_kept", sum_out, 8'd9);
    run_full("r3333", 16'h3333, 4'h3, 8'h0C, 3'd4);

    // Watchdog: stop never rises
    force_nostop = 1'b1;
    cypher_in = 16'h1234; compared_in = 4'h9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("wd_error_early", {7'd0, error}, 8'd0);
    tick();
    chk("wd_error", {7'd0, error}, 8'd1);
    chk("wd_ready", {7'd0, ready}, 8'd0);
    chk("wd_ctrl", {1'b0, ctrl_v}, 8'd0);
    start = 1'b1;
    repeat (3) tick();
    chk("wd_sticky", {7'd0, error}, 8'd1);
    chk("wd_sticky_ready", {7'd0, ready}, 8'd0);
    chk("wd_sticky_ctrl", {1'b0, ctrl_v}, 8'd0);
    chk("wd_sum_kept", sum_out, 8'h0C);
    start = 1'b0;
    force_nostop = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("wd_rst_error", {7'd0, error}, 8'd0);
    chk("wd_rst_ready", {7'd0, ready}, 8'd1);

    // Back-to-back with start held high
    cypher_in = 16'hFFFF; compared_in = 4'hF; start = 1'b1;
    tick();
    chk("b2b_load1", {1'b0, ctrl_v}, {1'b0, CTRL_LOAD});
    repeat (6) tick();
    chk("b2b_done1", {7'd0, done}, 8'd1);
    chk("b2b_sum1", sum_out, 8'h3C);
    cypher_in = 16'h3A33; compared_in = 4'h3;
    tick();
    chk("b2b_gap_ready", {7'd0, ready}, 8'd1);
    chk("b2b_gap_done", {7'd0, done}, 8'd0);
    tick();
    chk("b2b_load2", {1'b0, ctrl_v}, {1'b0, CTRL_LOAD});
    chk("b2b_load2_ready", {7'd0, ready}, 8'd0);
    repeat (6) tick();
    chk("b2b_done2", {7'd0, done}, 8'd1);
    chk("b2b_sum2", sum_out, 8'd9);
    chk("b2b_count2", {5'd0, match_count}, 8'd3);
    start = 1'b0;
    tick();
    chk("b2b_end_ready", {7'd0, ready}, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
